// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_pkg
//  Description : Shared game constants: controller state encodings and the
//                playfield geometry used by the collision and render blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package flappy_pkg;

  // Controller state encodings, also visible on the state output
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PLAYING   = 2'd1;
  localparam logic [1:0] ST_DYING     = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  // Playfield geometry shared with the collision detector and renderer
  localparam int FLOOR_Y     = 440;
  localparam int PIPE_SIZE_X = 64;

  // Larger of two integers, used to size shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/flappy_game_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_game_controller_if
//  Description : Event inputs and status/enable outputs of the game sequencer.
//                master = datapath side, slave = the controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface flappy_game_controller_if #(
  parameter int SCORE_W = 10
);

  logic               frame_tick;
  logic               flap_btn;
  logic               collision;
  logic               pipe_passed;
  logic [1:0]         state;
  logic               run_en;
  logic               fall_en;
  logic               world_reset;
  logic               flap_pulse;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               game_over;

  modport master (
    output frame_tick, flap_btn, collision, pipe_passed,
    input  state, run_en, fall_en, world_reset, flap_pulse,
           score, high_score, game_over
  );

  modport slave (
    input  frame_tick, flap_btn, collision, pipe_passed,
    output state, run_en, fall_en, world_reset, flap_pulse,
           score, high_score, game_over
  );

endinterface
`default_nettype wire

// File: rtl/frame_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_counter
//  Description : Tick-enabled counter with synchronous clear, terminal-count
//                compare against a run-time limit and optional saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic             saturate,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit
);

  logic [WIDTH-1:0] count;

  // Clear wins over a coincident tick so the entry tick is never counted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && !(saturate && at_limit)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign at_limit = (count == limit);

endmodule
`default_nettype wire

// File: rtl/flappy_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : flappy_game_controller
//  Description : Game sequencer IDLE -> PLAYING -> DYING -> GAME_OVER -> IDLE.
//                Gates bird/pipe advance, produces the flap impulse and keeps
//                the score and high score.
//  Revision    : 1.0  initial release
// ============================================================================
module flappy_game_controller
  import flappy_pkg::*;
#(
  parameter int DEATH_FRAMES = 60,
  parameter int OVER_HOLDOFF = 30,
  parameter int SCORE_W      = 10,
  parameter int MAX_SCORE    = 999
) (
  input  logic                     clk,
  input  logic                     reset,
  flappy_game_controller_if.slave  bus
);

  localparam int CNT_W = $clog2(max_int(DEATH_FRAMES, OVER_HOLDOFF) + 1);
  localparam logic [CNT_W-1:0]   DYING_LAST = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LAST  = CNT_W'(OVER_HOLDOFF);
  localparam logic [SCORE_W-1:0] SCORE_CAP  = SCORE_W'(MAX_SCORE);

  logic [1:0]         cur_state;
  logic [1:0]         next_state;
  logic               flap_q;
  logic               flap_edge;
  logic               flap_pulse;
  logic               cnt_clear;
  logic               cnt_tick;
  logic               cnt_sat;
  logic [CNT_W-1:0]   cnt_limit;
  logic               cnt_at_limit;
  logic [SCORE_W-1:0] score_reg;
  logic [SCORE_W-1:0] high_reg;

  assign flap_edge = bus.flap_btn & ~flap_q;

  // One counter serves both timed states; its limit follows the state
  assign cnt_tick  = bus.frame_tick & ((cur_state == ST_DYING) | (cur_state == ST_GAME_OVER));
  assign cnt_sat   = (cur_state == ST_GAME_OVER);
  assign cnt_limit = (cur_state == ST_DYING) ? DYING_LAST : HOLD_LAST;

  frame_counter #(
    .WIDTH (CNT_W)
  ) u_frame_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .tick     (cnt_tick),
    .saturate (cnt_sat),
    .limit    (cnt_limit),
    .at_limit (cnt_at_limit)
  );

  // Next-state decode; every entry into a timed phase restarts the counter
  always_comb begin
    next_state = cur_state;
    cnt_clear  = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (flap_edge) begin
          next_state = ST_PLAYING;
          cnt_clear  = 1'b1;
        end
      end
      ST_PLAYING: begin
        if (bus.collision && bus.frame_tick) begin
          next_state = ST_DYING;
          cnt_clear  = 1'b1;
        end
      end
      ST_DYING: begin
        if (bus.frame_tick && cnt_at_limit) begin
          next_state = ST_GAME_OVER;
          cnt_clear  = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (flap_edge && cnt_at_limit) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  // Button edge detect and registered flap impulse while the bird can fly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flap_q     <= 1'b0;
      flap_pulse <= 1'b0;
    end else begin
      flap_q     <= bus.flap_btn;
      flap_pulse <= flap_edge & ((cur_state == ST_IDLE) | (cur_state == ST_PLAYING));
    end
  end

  // Score saturates at the cap; high score latches when the death fall ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_reg <= '0;
      high_reg  <= '0;
    end else begin
      if (cur_state == ST_IDLE && flap_edge) begin
        score_reg <= '0;
      end else if (cur_state == ST_PLAYING && bus.pipe_passed && score_reg != SCORE_CAP) begin
        score_reg <= score_reg + SCORE_W'(1);
      end
      if (cur_state == ST_DYING && bus.frame_tick && cnt_at_limit && score_reg > high_reg) begin
        high_reg <= score_reg;
      end
    end
  end

  assign bus.state       = cur_state;
  assign bus.run_en      = (cur_state == ST_PLAYING);
  assign bus.fall_en     = (cur_state == ST_DYING);
  assign bus.world_reset = (cur_state == ST_IDLE);
  assign bus.game_over   = (cur_state == ST_GAME_OVER);
  assign bus.flap_pulse  = flap_pulse;
  assign bus.score       = score_reg;
  assign bus.high_score  = high_reg;

endmodule
`default_nettype wire

// File: tb/tb_flappy_game_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flappy_game_controller
//  Description : Self-checking bench: directed game scenarios followed by
//                random play, compared every cycle with a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flappy_game_controller;

  localparam int DF      = 60;
  localparam int OH      = 30;
  localparam int SW      = 10;
  localparam int MAXS    = 999;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: game phase 0..3, ticks seen in the current phase
  int m_state, m_ticks, m_score, m_high;
  bit m_prev, m_pulse;

  flappy_game_controller_if #(.SCORE_W(SW)) bus();

  flappy_game_controller #(
    .DEATH_FRAMES (DF),
    .OVER_HOLDOFF (OH),
    .SCORE_W      (SW),
    .MAX_SCORE    (MAXS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ticks = 0; m_score = 0; m_high = 0;
    m_prev  = 0; m_pulse = 0;
  endtask

  // One clock of game rules, applied to the inputs seen at that edge
  task automatic model_step(input bit btn, input bit tick, input bit col, input bit pipe);
    bit fl_edge;
    bit ready;
    fl_edge = btn && !m_prev;
    m_prev  = btn;
    m_pulse = fl_edge && (m_state == 0 || m_state == 1);
    case (m_state)
      0: if (fl_edge) begin m_state = 1; m_score = 0; m_ticks = 0; end
      1: begin
        if (pipe) m_score = (m_score + 1 > MAXS) ? MAXS : m_score + 1;
        if (col && tick) begin m_state = 2; m_ticks = 0; end
      end
      2: if (tick) begin
        m_ticks++;
        if (m_ticks == DF) begin
          m_state = 3; m_ticks = 0;
          if (m_score > m_high) m_high = m_score;
        end
      end
      default: begin
        ready = (m_ticks == OH);
        if (tick && m_ticks < OH) m_ticks++;
        if (fl_edge && ready) m_state = 0;
      end
    endcase
  endtask

  task automatic compare_all();
    check("state",       32'(bus.state),       m_state);
    check("run_en",      32'(bus.run_en),      32'(m_state == 1));
    check("fall_en",     32'(bus.fall_en),     32'(m_state == 2));
    check("world_reset", 32'(bus.world_reset), 32'(m_state == 0));
    check("game_over",   32'(bus.game_over),   32'(m_state == 3));
    check("flap_pulse",  32'(bus.flap_pulse),  32'(m_pulse));
    check("score",       32'(bus.score),       m_score);
    check("high_score",  32'(bus.high_score),  m_high);
  endtask

  // Apply inputs, advance one clock, compare just after the edge
  task automatic drive(input bit btn, input bit tick, input bit col, input bit pipe);
    bus.flap_btn    = btn;
    bus.frame_tick  = tick;
    bus.collision   = col;
    bus.pipe_passed = pipe;
    @(posedge clk);
    model_step(btn, tick, col, pipe);
    #1;
    compare_all();
  endtask

  task automatic press();
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 1, 0, 0);
      drive(0, 0, 0, 0);
    end
  endtask

  task automatic pipes(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 1);
  endtask

  initial begin
    bus.flap_btn = 0; bus.frame_tick = 0; bus.collision = 0; bus.pipe_passed = 0;
    model_reset();
    #1 reset = 1'b1;
    #1;
    check("rst_state", 32'(bus.state), 0);
    check("rst_world_reset", 32'(bus.world_reset), 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    compare_all();

    // First flap starts the game, impulse one cycle after the edge
    drive(1, 0, 0, 0);
    check("t1_pulse", 32'(bus.flap_pulse), 1);
    check("t1_run_en", 32'(bus.run_en), 1);
    drive(1, 0, 0, 0);
    check("t1_held_no_pulse", 32'(bus.flap_pulse), 0);
    drive(0, 0, 0, 0);

    // Scoring; collision without a frame tick is ignored
    pipes(5);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 0);
    check("t2_score5", 32'(bus.score), 5);
    check("t2_still_playing", 32'(bus.state), 1);
    drive(0, 1, 1, 0);
    check("t2_dying", 32'(bus.state), 2);

    // Death fall lasts exactly DEATH_FRAMES ticks
    ticks(DF - 1);
    check("t3_before_last", 32'(bus.state), 2);
    ticks(1);
    check("t3_game_over", 32'(bus.state), 3);
    check("t3_high5", 32'(bus.high_score), 5);

    // Hold-off ignores early flaps
    ticks(10);
    drive(1, 0, 0, 0);
    check("t4_early_ignored", 32'(bus.state), 3);
    check("t4_no_pulse", 32'(bus.flap_pulse), 0);
    drive(0, 0, 0, 0);
    ticks(OH - 10);
    press();
    check("t4_idle", 32'(bus.state), 0);
    check("t4_score_kept", 32'(bus.score), 5);

    // Second, lower game leaves the high score alone
    press();
    pipes(3);
    drive(0, 1, 1, 0);
    ticks(DF);
    check("t5_high_kept", 32'(bus.high_score), 5);
    ticks(OH);
    press();
    press();

    // Score saturation
    pipes(MAXS + 1);
    check("t6_saturate", 32'(bus.score), MAXS);
    drive(0, 1, 1, 0);
    ticks(DF);
    ticks(OH);
    press();
    press();

    // Same-cycle pass, collision and tick
    pipes(7);
    drive(0, 1, 1, 1);
    check("t7_score8", 32'(bus.score), 8);
    check("t7_dying", 32'(bus.state), 2);

    // Asynchronous reset mid-fall
    ticks(5);
    #2 reset = 1'b1;
    #1;
    check("t8_state", 32'(bus.state), 0);
    check("t8_score", 32'(bus.score), 0);
    check("t8_high", 32'(bus.high_score), 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    compare_all();

    // Random play against the model
    for (int i = 0; i < 8000; i++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
